// File: rtl/enigma_letter_sequencer_if.sv
// ============================================================================
// enigma_letter_sequencer_if
// Character stream, rotor-load and rotor-readback signals of the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface enigma_letter_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       cfg_load;
  logic [4:0] cfg_p0;
  logic [4:0] cfg_p1;
  logic [4:0] cfg_p2;
  logic [4:0] pos_p0;
  logic [4:0] pos_p1;
  logic [4:0] pos_p2;

  // Character source / sink and configuration side
  modport master (
    output in_data, in_valid, out_ready, cfg_load, cfg_p0, cfg_p1, cfg_p2,
    input  in_ready, out_data, out_valid, pos_p0, pos_p1, pos_p2
  );

  // Sequencer side
  modport slave (
    input  in_data, in_valid, out_ready, cfg_load, cfg_p0, cfg_p1, cfg_p2,
    output in_ready, out_data, out_valid, pos_p0, pos_p1, pos_p2
  );
endinterface

`default_nettype wire

// File: rtl/enigma_letter_sequencer.sv
// ============================================================================
// enigma_letter_sequencer
// Three-rotor Caesar-chain cipher, one arithmetic stage per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module enigma_letter_sequencer #(
  parameter logic [7:0] LETTER_A = 8'h41,
  parameter logic [7:0] LETTER_Z = 8'h5A,
  parameter int         STEP_EN  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  enigma_letter_sequencer_if.slave       bus
);

  localparam logic [7:0] REFL_SUM = LETTER_A + LETTER_Z;
  localparam logic [7:0] N_LET    = 8'd26;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_STEP = 4'd1,
    S_FWD0 = 4'd2,
    S_FWD1 = 4'd3,
    S_FWD2 = 4'd4,
    S_REFL = 4'd5,
    S_REV2 = 4'd6,
    S_REV1 = 4'd7,
    S_REV0 = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] c_q, c_d;
  logic [4:0] p0_q, p0_d;
  logic [4:0] p1_q, p1_d;
  logic [4:0] p2_q, p2_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic [4:0] stage_pos;
  logic [7:0] fwd_sum;
  logic [7:0] fwd_res;
  logic [7:0] rev_diff;
  logic [7:0] rev_res;
  logic       in_is_letter;

  function automatic logic [4:0] clamp_pos(input logic [4:0] v);
    return (v >= 5'd26) ? 5'd0 : v;
  endfunction

  function automatic logic [4:0] inc_pos(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  // One shared adder and subtractor serve every FWD/REV stage.
  always_comb begin
    stage_pos = 5'd0;
    case (state_q)
      S_FWD0, S_REV0: stage_pos = p0_q;
      S_FWD1, S_REV1: stage_pos = p1_q;
      S_FWD2, S_REV2: stage_pos = p2_q;
      default:        stage_pos = 5'd0;
    endcase
    fwd_sum  = c_q + {3'b000, stage_pos};
    fwd_res  = (fwd_sum > LETTER_Z) ? fwd_sum - N_LET : fwd_sum;
    rev_diff = c_q - {3'b000, stage_pos};
    rev_res  = (rev_diff < LETTER_A) ? rev_diff + N_LET : rev_diff;
  end

  assign in_is_letter = (bus.in_data >= LETTER_A) && (bus.in_data <= LETTER_Z);

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_load) begin
          p0_d = clamp_pos(bus.cfg_p0);
          p1_d = clamp_pos(bus.cfg_p1);
          p2_d = clamp_pos(bus.cfg_p2);
        end else if (bus.in_valid) begin
          c_d = bus.in_data;
          if (!in_is_letter) begin
            state_d     = S_DONE;
            out_data_d  = bus.in_data;
            out_valid_d = 1'b1;
          end else if (STEP_EN != 0) begin
            state_d = S_STEP;
          end else begin
            state_d = S_FWD0;
          end
        end
      end
      S_STEP: begin
        p0_d = inc_pos(p0_q);
        if (p0_q == 5'd25) begin
          p1_d = inc_pos(p1_q);
          if (p1_q == 5'd25) p2_d = inc_pos(p2_q);
        end
        state_d = S_FWD0;
      end
      S_FWD0: begin c_d = fwd_res; state_d = S_FWD1; end
      S_FWD1: begin c_d = fwd_res; state_d = S_FWD2; end
      S_FWD2: begin c_d = fwd_res; state_d = S_REFL; end
      S_REFL: begin c_d = REFL_SUM - c_q; state_d = S_REV2; end
      S_REV2: begin c_d = rev_res; state_d = S_REV1; end
      S_REV1: begin c_d = rev_res; state_d = S_REV0; end
      S_REV0: begin
        c_d         = rev_res;
        out_data_d  = rev_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      c_q         <= 8'h00;
      p0_q        <= 5'd0;
      p1_q        <= 5'd0;
      p2_q        <= 5'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Held low while reset is asserted even though the state already reads IDLE.
  assign bus.in_ready  = !reset && (state_q == S_IDLE) && !bus.cfg_load;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pos_p0    = p0_q;
  assign bus.pos_p1    = p1_q;
  assign bus.pos_p2    = p2_q;

endmodule

`default_nettype wire
